cpt_bin_mod: RTL and testbench
==============================

Name: cpt_bin_mod

Overview:
- Parametrised successor to the plain binary counter: an up/down modulo counter in the counter family.
- Adds a programmable last value, wrap or saturate at the boundaries, synchronous load and clear, a one-cycle boundary pulse and a sticky overflow flag.
- Intended as the base for decade counters, timers and address generators across the library.

Parameters:
- SIZE, 8, counter width in bits.
- MAX, 255, last count value; range is 0..MAX. Legal values are 1..2**SIZE-1; outside that range is an elaboration error.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- activate  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
- clear  input  1  synchronous clear.
- load  input  1  synchronous load.
- load_val  input  SIZE  value to load.
- cpt  output  SIZE  current count.
- tc  output  1  registered one-cycle boundary pulse.
- ovf  output  1  sticky boundary flag.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - cpt=0, tc=0, ovf=0.
  - Held for as long as reset=0.
  - Reset mid-count aborts immediately, with no pulse on tc.
- Priority at each rising clk edge: clear > load > activate. If none is asserted, cpt holds and tc=0.
- clear=1: cpt<=0, ovf<=0, tc<=0. activate and load are ignored that cycle.
- load=1 (clear=0):
  - cpt<=load_val if load_val<=MAX; otherwise cpt<=MAX (clamp).
  - tc<=0; ovf unchanged; activate ignored.
- activate=1 (clear=0, load=0):
  - up=1, cpt<MAX: cpt<=cpt+1.
  - up=1, cpt==MAX: boundary event. sat=0 -> cpt<=0; sat=1 -> cpt holds MAX.
  - up=0, cpt>0: cpt<=cpt-1.
  - up=0, cpt==0: boundary event. sat=0 -> cpt<=MAX; sat=1 -> cpt holds 0.
- Boundary event:
  - tc<=1 for exactly the following cycle; ovf<=1, sticky until clear or reset.
  - In saturate mode, every enabled cycle held at the boundary is a new boundary event, so tc stays high continuously.
- tc is 0 in every cycle not immediately following a boundary event.
- Direction changes take effect on the same edge. A boundary is judged against the current cpt and current up.
- Arithmetic is modulo-free internally: the next value never exceeds MAX, and no intermediate value wider than SIZE is exposed.
- Latency:
  - cpt and tc update at the edge where the controls are sampled.
  - No combinational path from inputs to outputs.
- Inputs are sampled only at rising clk. Glitches between edges have no effect.

Test Plan:
- Reset and hold: reset=0 for 2 cycles with activate=1 -> cpt=0, tc=0, ovf=0 throughout. Release reset -> first edge gives cpt=1.
- Decade wrap (MAX=9, up=1, sat=0, activate=1, 12 edges from 0) -> cpt goes 1..9,0,1,2. tc=1 only in the cycle after 9->0. ovf=1 from that point.
- Down saturate (MAX=9, load_val=2 loaded, then up=0, sat=1, 5 edges) -> cpt goes 1,0,0,0,0. tc=1 for 3 consecutive cycles. ovf=1.
- Load clamp and priority (SIZE=8, MAX=200):
  - load=1, load_val=250 -> cpt=200.
  - Same edge with clear=1, load=1, activate=1 -> cpt=0, ovf=0.
- Full-range free-run (SIZE=8, MAX=255, up=1, sat=0) for 256 edges from 0 -> cpt returns to 0 exactly once, with a single tc pulse. No edge repeats a cpt value while activate=1 (stall check).
- Async reset mid-operation: assert reset=0 between edges at cpt=137 -> cpt=0 before the next edge, ovf cleared, no tc pulse.

Source files
------------

// File: rtl/cpt_bin_mod_if.sv
// Control and status bundle for the cpt_bin_mod up/down modulo counter.
// The master side drives the count controls and the slave (the counter)
// returns the current count, the boundary pulse and the sticky flag.
interface cpt_bin_mod_if #(
  parameter int SIZE = 8
);
  logic            activate;
  logic            up;
  logic            sat;
  logic            clear;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] cpt;
  logic            tc;
  logic            ovf;

  modport master (
    output activate, up, sat, clear, load, load_val,
    input  cpt, tc, ovf
  );

  modport slave (
    input  activate, up, sat, clear, load, load_val,
    output cpt, tc, ovf
  );
endinterface

// File: rtl/cpt_bin_mod.sv
// Up/down modulo counter over the range 0..MAX with wrap or saturate at the
// boundaries, synchronous clear and clamped load, a registered one-cycle
// boundary pulse (tc) and a sticky boundary flag (ovf).
// Controls are prioritised clear > load > activate. All outputs come
// straight from flops, so there is no combinational input-to-output path.
module cpt_bin_mod #(
  parameter int SIZE = 8,
  parameter int MAX  = 255
) (
  input  logic           clk,
  input  logic           reset,
  cpt_bin_mod_if.slave   bus
);

  // Largest value representable in SIZE bits, computed wide enough that the
  // legality check below cannot itself overflow.
  localparam longint CAP = (longint'(1) << SIZE) - 1;

  // MAX must leave at least two states and must fit in the counter width.
  if ((MAX < 1) || (longint'(MAX) > CAP)) begin : gBadMax
    $error("cpt_bin_mod: MAX=%0d is outside the legal range 1..%0d", MAX, CAP);
  end

  // The interface width has to agree with the counter width.
  if ($bits(bus.cpt) != SIZE) begin : gBadWidth
    $error("cpt_bin_mod: interface width %0d does not match SIZE=%0d",
           $bits(bus.cpt), SIZE);
  end

  localparam logic [SIZE-1:0] MAXV = SIZE'(MAX);
  localparam logic [SIZE-1:0] ONE  = {{(SIZE-1){1'b0}}, 1'b1};

  logic [SIZE-1:0] cptQ;
  logic            tcQ;
  logic            ovfQ;

  logic [SIZE-1:0] cptNext;
  logic            tcNext;
  logic            ovfNext;
  logic            atTop;
  logic            atBottom;

  // Boundaries are judged on the present count, so the next value is always
  // either a +/-1 step strictly inside 0..MAX or an explicit wrap/hold value;
  // no carry or borrow beyond SIZE bits is ever formed.
  assign atTop    = (cptQ == MAXV);
  assign atBottom = (cptQ == '0);

  // Next-state selection: clear beats load beats activate; tc only rises
  // on a boundary event and is otherwise low for the following cycle.
  always_comb begin
    cptNext = cptQ;
    tcNext  = 1'b0;
    ovfNext = ovfQ;
    if (bus.clear) begin
      cptNext = '0;
      ovfNext = 1'b0;
    end else if (bus.load) begin
      cptNext = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    end else if (bus.activate) begin
      if (bus.up) begin
        if (atTop) begin
          tcNext  = 1'b1;
          ovfNext = 1'b1;
          cptNext = bus.sat ? MAXV : '0;
        end else begin
          cptNext = cptQ + ONE;
        end
      end else begin
        if (atBottom) begin
          tcNext  = 1'b1;
          ovfNext = 1'b1;
          cptNext = bus.sat ? '0 : MAXV;
        end else begin
          cptNext = cptQ - ONE;
        end
      end
    end
  end

  // State registers; an active-low reset clears everything immediately,
  // cancelling any pending tc pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cptQ <= '0;
      tcQ  <= 1'b0;
      ovfQ <= 1'b0;
    end else begin
      cptQ <= cptNext;
      tcQ  <= tcNext;
      ovfQ <= ovfNext;
    end
  end

  assign bus.cpt = cptQ;
  assign bus.tc  = tcQ;
  assign bus.ovf = ovfQ;

endmodule

// File: tb/tb_cpt_bin_mod.sv
// Scoreboard bench for cpt_bin_mod. Three counters (MAX = 9, 200, 255, all
// 8 bits wide) share one set of controls. Each clock edge the driver
// advances an arithmetic reference model and queues the expected outputs;
// an independent monitor pops and compares them on the falling edge, or
// immediately when an asynchronous reset is applied between edges.
module tb_cpt_bin_mod;

  localparam int NDUT = 3;
  localparam int MAXES [NDUT] = '{9, 200, 255};

  typedef struct packed {
    logic [NDUT-1:0][7:0] c;
    logic [NDUT-1:0]      t;
    logic [NDUT-1:0]      o;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       activate;
  logic       up;
  logic       sat;
  logic       clear;
  logic       load;
  logic [7:0] loadVal;

  int checks;
  int failures;

  exp_t expQ [$];
  event sampleEv;

  int mCpt [NDUT];
  bit mTc  [NDUT];
  bit mOvf [NDUT];

  logic [7:0] aCpt [NDUT];
  logic       aTc  [NDUT];
  logic       aOvf [NDUT];

  cpt_bin_mod_if #(.SIZE(8)) bus0 ();
  cpt_bin_mod_if #(.SIZE(8)) bus1 ();
  cpt_bin_mod_if #(.SIZE(8)) bus2 ();

  cpt_bin_mod #(.SIZE(8), .MAX(9))   dut0 (.clk(clk), .reset(reset), .bus(bus0));
  cpt_bin_mod #(.SIZE(8), .MAX(200)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  cpt_bin_mod #(.SIZE(8), .MAX(255)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.activate = activate;
  assign bus0.up       = up;
  assign bus0.sat      = sat;
  assign bus0.clear    = clear;
  assign bus0.load     = load;
  assign bus0.load_val = loadVal;
  assign bus1.activate = activate;
  assign bus1.up       = up;
  assign bus1.sat      = sat;
  assign bus1.clear    = clear;
  assign bus1.load     = load;
  assign bus1.load_val = loadVal;
  assign bus2.activate = activate;
  assign bus2.up       = up;
  assign bus2.sat      = sat;
  assign bus2.clear    = clear;
  assign bus2.load     = load;
  assign bus2.load_val = loadVal;

  assign aCpt[0] = bus0.cpt;
  assign aCpt[1] = bus1.cpt;
  assign aCpt[2] = bus2.cpt;
  assign aTc[0]  = bus0.tc;
  assign aTc[1]  = bus1.tc;
  assign aTc[2]  = bus2.tc;
  assign aOvf[0] = bus0.ovf;
  assign aOvf[1] = bus1.ovf;
  assign aOvf[2] = bus2.ovf;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model for one edge: step by +/-1 in plain integers; leaving
  // 0..MAX is a boundary event that either wraps or leaves the count alone.
  function automatic void modelEdge();
    int nxt;
    for (int i = 0; i < NDUT; i++) begin
      if (!reset) begin
        mCpt[i] = 0;
        mTc[i]  = 1'b0;
        mOvf[i] = 1'b0;
      end else if (clear) begin
        mCpt[i] = 0;
        mTc[i]  = 1'b0;
        mOvf[i] = 1'b0;
      end else if (load) begin
        mCpt[i] = (int'(loadVal) > MAXES[i]) ? MAXES[i] : int'(loadVal);
        mTc[i]  = 1'b0;
      end else if (activate) begin
        nxt = mCpt[i] + (up ? 1 : -1);
        if (nxt < 0 || nxt > MAXES[i]) begin
          mTc[i]  = 1'b1;
          mOvf[i] = 1'b1;
          if (!sat) mCpt[i] = (nxt < 0) ? MAXES[i] : 0;
        end else begin
          mCpt[i] = nxt;
          mTc[i]  = 1'b0;
        end
      end else begin
        mTc[i] = 1'b0;
      end
    end
  endfunction

  // Snapshot the model state into the scoreboard queue.
  function automatic void pushExpect();
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      e.c[i] = mCpt[i][7:0];
      e.t[i] = mTc[i];
      e.o[i] = mOvf[i];
    end
    expQ.push_back(e);
  endfunction

  // Compare every counter against one expected snapshot.
  task automatic checkOutput(input exp_t e);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (aCpt[i] !== e.c[i]) begin
        failures++;
        $display("[TB] FAIL cpt_max%0d got=%0d want=%0d at %0t", MAXES[i], aCpt[i], e.c[i], $time);
      end
      checks++;
      if (aTc[i] !== e.t[i]) begin
        failures++;
        $display("[TB] FAIL tc_max%0d got=%0b want=%0b at %0t", MAXES[i], aTc[i], e.t[i], $time);
      end
      checks++;
      if (aOvf[i] !== e.o[i]) begin
        failures++;
        $display("[TB] FAIL ovf_max%0d got=%0b want=%0b at %0t", MAXES[i], aOvf[i], e.o[i], $time);
      end
    end
  endtask

  // Drive one set of controls, let the edge happen, and queue the result.
  task automatic applyStimulus(input bit act, input bit u, input bit s,
                               input bit clr, input bit ld, input logic [7:0] lv);
    activate = act;
    up       = u;
    sat      = s;
    clear    = clr;
    load     = ld;
    loadVal  = lv;
    @(posedge clk);
    modelEdge();
    pushExpect();
    #1;
  endtask

  // Pull reset low between edges and sample before the next rising edge.
  task automatic asyncReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      mCpt[i] = 0;
      mTc[i]  = 1'b0;
      mOvf[i] = 1'b0;
    end
    #1;
    pushExpect();
    -> sampleEv;
  endtask

  // Monitor: consume expectations on each falling edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sampleEv);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < NDUT; i++) begin
      mCpt[i] = 0;
      mTc[i]  = 1'b0;
      mOvf[i] = 1'b0;
    end
    reset    = 1'b0;
    activate = 1'b1;
    up       = 1'b1;
    sat      = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    loadVal  = '0;

    // Reset held for two edges with counting requested, then released.
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 8'd0);
    #2 reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 8'd0);

    // Clear, then count up twelve edges: decade wraps 9 -> 0 once.
    applyStimulus(0, 1, 0, 1, 0, 8'd0);
    repeat (12) applyStimulus(1, 1, 0, 0, 0, 8'd0);

    // Load 2, then count down in saturate mode into the floor.
    applyStimulus(0, 0, 1, 0, 1, 8'd2);
    repeat (5) applyStimulus(1, 0, 1, 0, 0, 8'd0);

    // Clamped load, then clear beating load and activate on one edge.
    applyStimulus(0, 1, 0, 0, 1, 8'd250);
    applyStimulus(1, 1, 0, 1, 1, 8'd100);

    // Saturate upward at the top, then wrap downward at the bottom.
    applyStimulus(0, 1, 1, 0, 1, 8'd255);
    repeat (3) applyStimulus(1, 1, 1, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 0, 1, 8'd0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 8'd0);

    // Full-range free run from zero for 256 edges.
    applyStimulus(0, 1, 0, 1, 0, 8'd0);
    repeat (256) applyStimulus(1, 1, 0, 0, 0, 8'd0);

    // Count to 137, then reset asynchronously between edges.
    applyStimulus(0, 1, 0, 0, 1, 8'd130);
    repeat (7) applyStimulus(1, 1, 0, 0, 0, 8'd0);
    asyncReset();
    #2;
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 8'd0);
    #2 reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 8'd0);

    // Randomised mix of all controls.
    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 9) == 0,
                    8'($urandom_range(0, 255)));
    end

    // Let the monitor drain the queue, then confirm nothing was left behind.
    activate = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
